// File: rtl/rx_engine_control.sv
// UART receive control: RX synchroniser, start-bit validation, bit-centre timing and START/BTU/DONE strobes.
// Latency: RX to RX_S is SYNC_STAGES clk; strobes are combinational from state, with no backpressure (free-running strobes).
module rx_engine_control #(
  parameter int SYNC_STAGES = 2,
  parameter int BT_W        = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic [3:0] BAUD,
  input  logic       EIGHT,
  input  logic       PEN,
  output logic       RX_S,
  output logic       START,
  output logic       BTU,
  output logic       DONE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STRT   = 2'd1,
    DATA   = 2'd2,
    DONE_S = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [BT_W-1:0]   bt_cnt_q, bt_cnt_d;
  logic [BT_W-1:0]   k_q, k_d;
  logic [BT_W-1:0]   target;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        n_q, n_d;
  logic [3:0]        bit_cnt_inc;
  logic              bt_hit;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
    end
  end

  assign RX_S = sync_q[SYNC_STAGES-1];

  function automatic logic [BT_W-1:0] baud_div(input logic [3:0] code);
    case (code)
      4'h0:    baud_div = BT_W'(333333);
      4'h1:    baud_div = BT_W'(83333);
      4'h2:    baud_div = BT_W'(41667);
      4'h3:    baud_div = BT_W'(20833);
      4'h4:    baud_div = BT_W'(10417);
      4'h5:    baud_div = BT_W'(5208);
      4'h6:    baud_div = BT_W'(2604);
      4'h7:    baud_div = BT_W'(1736);
      4'h8:    baud_div = BT_W'(868);
      4'h9:    baud_div = BT_W'(434);
      4'hA:    baud_div = BT_W'(217);
      4'hB:    baud_div = BT_W'(109);
      default: baud_div = BT_W'(10417);
    endcase
  endfunction

  // Half a bit in STRT lands on the start-bit centre; full bits thereafter.
  assign target      = (state_q == STRT) ? (k_q >> 1) : k_q;
  assign bt_hit      = ((state_q == STRT) || (state_q == DATA)) && (bt_cnt_q == target);
  assign bit_cnt_inc = bit_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bt_cnt_q  <= '0;
      bit_cnt_q <= '0;
      k_q       <= '0;
      n_q       <= '0;
    end else begin
      state_q   <= state_d;
      bt_cnt_q  <= bt_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      k_q       <= k_d;
      n_q       <= n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bt_cnt_d  = bt_cnt_q;
    bit_cnt_d = bit_cnt_q;
    k_d       = k_q;
    n_d       = n_q;
    case (state_q)
      IDLE: begin
        bt_cnt_d = '0;
        if (!RX_S) begin
          state_d   = STRT;
          k_d       = baud_div(BAUD);
          n_d       = 4'd8 + {3'b000, EIGHT} + {3'b000, PEN};
          bit_cnt_d = '0;
        end
      end
      STRT: begin
        if (bt_hit) begin
          bt_cnt_d = '0;
          state_d  = RX_S ? IDLE : DATA;
        end else begin
          bt_cnt_d = bt_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bt_hit) begin
          bt_cnt_d  = '0;
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_inc == n_q) begin
            state_d = DONE_S;
          end
        end else begin
          bt_cnt_d = bt_cnt_q + 1'b1;
        end
      end
      DONE_S: begin
        bt_cnt_d = '0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are masked while rst is high so a reset landing on a bit centre issues nothing.
  assign START = (state_q == STRT) && !rst;
  assign BTU   = bt_hit && !rst;
  assign DONE  = (state_q == DONE_S) && !rst;

endmodule

// File: tb/tb_rx_engine_control.sv
// Bench for rx_engine_control: frame-level timing model checked every cycle, plus literal frame measurements.
module tb_rx_engine_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b0;
  logic [3:0] BAUD = 4'hB;
  logic       EIGHT = 1'b1;
  logic       PEN = 1'b0;
  logic       RX_S, START, BTU, DONE;

  always #5 clk = ~clk;

  rx_engine_control dut (
    .clk(clk), .rst(rst), .RX(RX), .BAUD(BAUD), .EIGHT(EIGHT), .PEN(PEN),
    .RX_S(RX_S), .START(START), .BTU(BTU), .DONE(DONE)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int btu_cnt = 0, done_cnt = 0, start_cnt = 0;
  int start_rise = -1, done_cyc = -1;
  int btu_q[$];

  function automatic int div_of(input logic [3:0] b);
    case (b)
      4'h0: return 333333;  4'h1: return 83333;  4'h2: return 41667;  4'h3: return 20833;
      4'h4: return 10417;   4'h5: return 5208;   4'h6: return 2604;   4'h7: return 1736;
      4'h8: return 868;     4'h9: return 434;    4'hA: return 217;    4'hB: return 109;
      default: return 10417;
    endcase
  endfunction

  function automatic int qat(input int idx);
    if (idx < 0 || idx >= btu_q.size()) return -1;
    return btu_q[idx];
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: a frame starts the cycle after idle sees RX_S low; all strobes follow from s, K, N by arithmetic.
  initial begin
    bit started = 0, p0 = 1, e_rxs = 1, prev_rxs = 1, in_frame = 0, prev_start = 0;
    bit e_start, e_btu, e_done;
    int s = 0, k = 0, n = 0, h = 0, res = -1, off;
    forever begin
      @(posedge clk);
      cyc++;
      prev_rxs = e_rxs;
      if (rst) begin
        started = 1; p0 = 1; e_rxs = 1; in_frame = 0; res = -1;
      end else begin
        if (!in_frame) begin
          if (!prev_rxs) begin
            in_frame = 1; s = cyc; k = div_of(BAUD); n = 8 + EIGHT + PEN; h = k / 2; res = -1;
          end
        end else if ((res == 0 && cyc == s + h + 1) || (res == 1 && cyc == s + h + n * (k + 1) + 2)) begin
          in_frame = 0;
        end
        e_rxs = p0;
        p0 = RX;
        if (in_frame && cyc == s + h) res = e_rxs ? 0 : 1;
      end
      e_start = 0; e_btu = 0; e_done = 0;
      if (!rst && in_frame) begin
        off = cyc - (s + h);
        e_start = (off <= 0);
        e_btu = (off == 0) || (res == 1 && off > 0 && off % (k + 1) == 0 && off / (k + 1) <= n);
        e_done = (res == 1 && off == n * (k + 1) + 1);
      end
      #1;
      if (started) begin
        vectors++;
        if ({RX_S, START, BTU, DONE} !== {e_rxs, e_start, e_btu, e_done}) begin
          miscompares++;
          $display("FAIL cycle %0d RX_S/START/BTU/DONE: got %b%b%b%b expected %b%b%b%b",
                   cyc, RX_S, START, BTU, DONE, e_rxs, e_start, e_btu, e_done);
        end
        if (BTU === 1'b1) begin btu_cnt++; btu_q.push_back(cyc); end
        if (DONE === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (START === 1'b1) start_cnt++;
        if (START === 1'b1 && !prev_start) start_rise = cyc;
        prev_start = (START === 1'b1);
      end
    end
  end

  // Bit period K+1 keeps every driven bit centred on the DUT's BTU.
  task automatic send_frame(input int k, input logic [7:0] d, input int nd, input bit par_en,
                            input int rst_bit, input bit chg, input logic [3:0] nb, input bit ne);
    logic [10:0] bits;
    int total;
    bit par;
    par = 0;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      bits[1 + i] = d[i];
      par ^= d[i];
    end
    total = 1 + nd;
    if (par_en) begin bits[total] = par; total++; end
    bits[total] = 1'b1;
    total++;
    for (int b = 0; b < total; b++) begin
      for (int c = 0; c <= k; c++) begin
        @(negedge clk);
        RX = bits[b];
        if (b == rst_bit && c == k / 2 + 2) rst = 1'b1;
        if (b == rst_bit && c == k / 2 + 4) rst = 1'b0;
        if (chg && b == 3 && c == 0) begin BAUD = nb; EIGHT = ne; end
      end
    end
  endtask

  int b0, d0, s0, q0, r;
  int sw_baud[4] = '{9, 10, 12, 7};
  int sw_len[4]  = '{218, 109, 5209, 869};

  task automatic snap();
    b0 = btu_cnt; d0 = done_cnt; s0 = start_cnt; q0 = btu_q.size();
  endtask

  initial begin
    // Reset held three edges with RX low.
    repeat (3) @(negedge clk);
    chk("reset_rx_s", int'(RX_S), 1);
    chk("reset_start", int'(START), 0);
    chk("reset_btu", int'(BTU), 0);
    chk("reset_done", int'(DONE), 0);
    r = cyc;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    RX = 1'b1;
    chk("strt_after_reset", start_rise - r, 3);
    repeat (100) @(negedge clk);

    BAUD = 4'h8; EIGHT = 1'b1; PEN = 1'b0;
    snap();
    send_frame(868, 8'h55, 8, 0, -1, 0, 4'h0, 0);
    repeat (20) @(negedge clk);
    chk("8n1_btus", btu_cnt - b0, 10);
    chk("8n1_dones", done_cnt - d0, 1);
    chk("8n1_start_len", start_cnt - s0, 435);
    chk("8n1_first_data_btu", qat(q0 + 1) - start_rise, 1303);
    chk("8n1_spacing", qat(q0 + 2) - qat(q0 + 1), 869);
    chk("8n1_span", qat(q0 + 9) - qat(q0 + 1), 6952);
    chk("8n1_done_after_btu", done_cyc - qat(q0 + 9), 1);

    PEN = 1'b1;
    snap();
    send_frame(868, 8'hA5, 8, 1, -1, 0, 4'h0, 0);
    repeat (20) @(negedge clk);
    chk("8p1_btus", btu_cnt - b0, 11);
    chk("8p1_dones", done_cnt - d0, 1);

    EIGHT = 1'b0; PEN = 1'b0;
    snap();
    send_frame(868, 8'h2C, 7, 0, -1, 0, 4'h0, 0);
    repeat (20) @(negedge clk);
    chk("7n1_btus", btu_cnt - b0, 9);
    chk("7n1_dones", done_cnt - d0, 1);

    EIGHT = 1'b1;
    snap();
    RX = 1'b0;
    repeat (200) @(negedge clk);
    RX = 1'b1;
    repeat (600) @(negedge clk);
    chk("glitch_btus", btu_cnt - b0, 1);
    chk("glitch_dones", done_cnt - d0, 0);
    chk("glitch_start_len", start_cnt - s0, 435);

    // BAUD and EIGHT change during bit 3; only the following frame may see them.
    snap();
    send_frame(868, 8'h3C, 8, 0, -1, 1, 4'hB, 0);
    repeat (20) @(negedge clk);
    chk("mid_btus", btu_cnt - b0, 10);
    chk("mid_dones", done_cnt - d0, 1);
    chk("mid_spacing", qat(q0 + 2) - qat(q0 + 1), 869);
    snap();
    send_frame(109, 8'h5A, 7, 0, -1, 0, 4'h0, 0);
    repeat (20) @(negedge clk);
    chk("next_btus", btu_cnt - b0, 9);
    chk("next_dones", done_cnt - d0, 1);
    chk("next_spacing", qat(q0 + 2) - qat(q0 + 1), 110);
    chk("next_span", qat(q0 + 8) - qat(q0 + 1), 770);

    EIGHT = 1'b1;
    snap();
    send_frame(109, 8'hFF, 8, 0, 5, 0, 4'h0, 0);
    repeat (20) @(negedge clk);
    chk("rst_mid_btus", btu_cnt - b0, 5);
    chk("rst_mid_dones", done_cnt - d0, 0);
    snap();
    send_frame(109, 8'h96, 8, 0, -1, 0, 4'h0, 0);
    repeat (20) @(negedge clk);
    chk("post_rst_btus", btu_cnt - b0, 10);
    chk("post_rst_dones", done_cnt - d0, 1);

    snap();
    send_frame(109, 8'h00, 8, 0, -1, 0, 4'h0, 0);
    send_frame(109, 8'hFF, 8, 0, -1, 0, 4'h0, 0);
    repeat (20) @(negedge clk);
    chk("b2b_dones", done_cnt - d0, 2);
    chk("b2b_btus", btu_cnt - b0, 20);
    chk("b2b_gap", qat(q0 + 10) - qat(q0 + 9), 110);

    // Short false starts across more table entries, including an unused code.
    for (int i = 0; i < 4; i++) begin
      BAUD = 4'(sw_baud[i]);
      snap();
      RX = 1'b0;
      repeat (30) @(negedge clk);
      RX = 1'b1;
      repeat (sw_len[i] + 60) @(negedge clk);
      chk("sweep_start_len", start_cnt - s0, sw_len[i]);
      chk("sweep_btus", btu_cnt - b0, 1);
      chk("sweep_dones", done_cnt - d0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
